// File: rtl/video_clk_supervisor.sv
// Video PLL supervisor: mode select, PLL reset/lock sequencing, pixel-clock frequency check.
// Latency: ready rises one cycle after RUN is entered; pll_lock/meas_tog see 2-flop sync delay.
// Backpressure: none; mode_req is a single-cycle strobe and is always accepted or flagged via bad_req.
module video_clk_supervisor #(
    parameter int NUM_MODES     = 3,
    parameter int MODE_W        = 2,
    parameter int DEFAULT_MODE  = 1,
    parameter int CNT_W         = 16,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int WINDOW        = 5000,
    parameter logic [NUM_MODES*CNT_W-1:0] EXP_COUNTS = {16'd232, 16'd116, 16'd42},
    parameter int TOL           = 3,
    parameter int MAX_RETRY     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              mode_req,
    input  logic              pll_lock,
    input  logic              meas_tog,
    output logic              pll_reset,
    output logic [MODE_W-1:0] pll_mode,
    output logic              video_rst_n,
    output logic              ready,
    output logic              lock_lost,
    output logic              error,
    output logic              bad_req,
    output logic [CNT_W-1:0]  meas_count
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST  = CNT_W'(WINDOW - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_SETTLE,
        S_MEASURE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   timer;
    logic [CNT_W-1:0]   edge_cnt;
    logic [RETRY_W-1:0] retry_cnt;

    logic lock_meta, lock_s;
    logic tog_meta, tog_s, tog_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            tog_meta  <= 1'b0;
            tog_s     <= 1'b0;
            tog_d     <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            tog_meta  <= meas_tog;
            tog_s     <= tog_meta;
            tog_d     <= tog_s;
        end
    end

    logic             tog_edge;
    logic             req_ok;
    logic [CNT_W-1:0] timer_inc;
    logic [CNT_W-1:0] win_cnt_next;
    logic [CNT_W-1:0] exp_cnt;
    logic [CNT_W-1:0] diff;
    logic             in_tol;
    logic             window_end;
    logic             retry_hit;
    logic             retry_exhausted;

    assign tog_edge        = tog_s ^ tog_d;
    assign req_ok          = mode_req && (int'(mode_sel) < NUM_MODES);
    assign timer_inc       = (timer == CNT_MAX) ? timer : timer + 1'b1;
    assign window_end      = (state == S_MEASURE) && lock_s && (timer == WINDOW_LAST);
    assign retry_exhausted = (retry_cnt >= RETRY_W'(MAX_RETRY - 1));

    // The edge of the final window cycle is folded in so the latched count covers all WINDOW cycles.
    always_comb begin
        win_cnt_next = edge_cnt;
        if (tog_edge && edge_cnt != CNT_MAX) begin
            win_cnt_next = edge_cnt + 1'b1;
        end
        exp_cnt = EXP_COUNTS[int'(pll_mode)*CNT_W +: CNT_W];
        diff    = (win_cnt_next >= exp_cnt) ? win_cnt_next - exp_cnt : exp_cnt - win_cnt_next;
        in_tol  = (diff <= CNT_W'(TOL));
    end

    always_comb begin
        retry_hit = 1'b0;
        case (state)
            S_WAIT_LOCK: retry_hit = !lock_s && (timer == TIMEOUT_LAST);
            S_SETTLE:    retry_hit = !lock_s;
            S_MEASURE:   retry_hit = !lock_s || (window_end && !in_tol);
            default:     retry_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_PLL_RST;
            timer       <= '0;
            edge_cnt    <= '0;
            retry_cnt   <= '0;
            pll_reset   <= 1'b1;
            pll_mode    <= MODE_W'(DEFAULT_MODE);
            video_rst_n <= 1'b0;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            error       <= 1'b0;
            bad_req     <= 1'b0;
            meas_count  <= '0;
        end else begin
            bad_req <= mode_req && !req_ok;
            if (req_ok) begin
                // A valid request overrides whatever the sequencer would have done this cycle.
                state       <= S_PLL_RST;
                timer       <= '0;
                retry_cnt   <= '0;
                pll_reset   <= 1'b1;
                pll_mode    <= mode_sel;
                video_rst_n <= 1'b0;
                ready       <= 1'b0;
                lock_lost   <= 1'b0;
                error       <= 1'b0;
            end else begin
                if (window_end) begin
                    meas_count <= win_cnt_next;
                end
                if (retry_hit) begin
                    state     <= retry_exhausted ? S_FAIL : S_PLL_RST;
                    retry_cnt <= retry_cnt + 1'b1;
                    error     <= retry_exhausted;
                    pll_reset <= 1'b1;
                    timer     <= '0;
                end else begin
                    case (state)
                        S_PLL_RST: begin
                            if (timer == RST_LAST) begin
                                state     <= S_WAIT_LOCK;
                                timer     <= '0;
                                pll_reset <= 1'b0;
                            end else begin
                                timer <= timer_inc;
                            end
                        end
                        S_WAIT_LOCK: begin
                            if (lock_s) begin
                                state <= S_SETTLE;
                                timer <= '0;
                            end else begin
                                timer <= timer_inc;
                            end
                        end
                        S_SETTLE: begin
                            if (timer == SETTLE_LAST) begin
                                state    <= S_MEASURE;
                                timer    <= '0;
                                edge_cnt <= '0;
                            end else begin
                                timer <= timer_inc;
                            end
                        end
                        S_MEASURE: begin
                            if (window_end) begin
                                state     <= S_RUN;
                                retry_cnt <= '0;
                            end else begin
                                timer    <= timer_inc;
                                edge_cnt <= win_cnt_next;
                            end
                        end
                        S_RUN: begin
                            if (!lock_s) begin
                                state       <= S_PLL_RST;
                                timer       <= '0;
                                pll_reset   <= 1'b1;
                                lock_lost   <= 1'b1;
                                video_rst_n <= 1'b0;
                                ready       <= 1'b0;
                            end else begin
                                video_rst_n <= 1'b1;
                                ready       <= 1'b1;
                            end
                        end
                        S_FAIL: begin
                            error     <= 1'b1;
                            pll_reset <= 1'b1;
                        end
                        default: state <= S_PLL_RST;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_video_clk_supervisor.sv
// Directed bench for video_clk_supervisor: bring-up, lock loss, wrong rate, bad/racing requests, lock timeout.
`timescale 1ns/1ps
module tb_video_clk_supervisor;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode_sel;
    logic        mode_req;
    logic        pll_lock;
    logic        meas_tog;
    logic        pll_reset;
    logic [1:0]  pll_mode;
    logic        video_rst_n;
    logic        ready;
    logic        lock_lost;
    logic        error;
    logic        bad_req;
    logic [15:0] meas_count;

    int  n_checks = 0;
    int  n_fail   = 0;
    real tog_half = 861.953;   // 64 pixel clocks at 74.25 MHz

    // Shorter lock timeout keeps the four-attempt timeout scenario inside the cycle budget.
    video_clk_supervisor #(
        .NUM_MODES(3), .MODE_W(2), .DEFAULT_MODE(1), .CNT_W(16), .RST_CYCLES(16),
        .LOCK_TIMEOUT(1000), .SETTLE_CYCLES(1024), .WINDOW(5000),
        .EXP_COUNTS({16'd232, 16'd116, 16'd42}), .TOL(3), .MAX_RETRY(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .mode_req(mode_req),
        .pll_lock(pll_lock), .meas_tog(meas_tog), .pll_reset(pll_reset),
        .pll_mode(pll_mode), .video_rst_n(video_rst_n), .ready(ready),
        .lock_lost(lock_lost), .error(error), .bad_req(bad_req), .meas_count(meas_count)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        meas_tog = 1'b0;
        forever begin
            #(tog_half);
            meas_tog = ~meas_tog;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int bound, output int cyc);
        cyc = 0;
        while (ready !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ready"}, ready, 1);
        check({tag, "_vrst"}, video_rst_n, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_reset"}, pll_reset, 1);
        check({tag, "_pll_mode"}, pll_mode, 1);
        check({tag, "_vrst"}, video_rst_n, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_lock_lost"}, lock_lost, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_bad_req"}, bad_req, 0);
        check({tag, "_meas"}, meas_count, 0);
    endtask

    initial begin
        int cyc;
        int total;
        int ready_seen;
        logic [15:0] prev_meas;

        rst_n = 1'b0; mode_sel = 2'd0; mode_req = 1'b0; pll_lock = 1'b0;
        #35;
        check_reset_vals("rst");

        // Bring-up in 720p: lock 100 cycles after pll_reset falls.
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (pll_reset && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_len", cyc, 16);
        repeat (100) @(negedge clk);
        pll_lock = 1'b1;
        wait_ready("bringup", 7000, cyc);
        total = 16 + 100 + cyc;
        check("bringup_time", (total >= 6137 && total <= 6150), 1);
        check("bringup_meas", (meas_count >= 113 && meas_count <= 119), 1);
        check("bringup_mode", pll_mode, 1);
        check("bringup_pll_reset", pll_reset, 0);

        // Out-of-range mode request is flagged and ignored.
        mode_sel = 2'd3; mode_req = 1'b1;
        @(negedge clk);
        mode_req = 1'b0;
        check("badreq_pulse", bad_req, 1);
        check("badreq_ready", ready, 1);
        check("badreq_mode", pll_mode, 1);
        @(negedge clk);
        check("badreq_clear", bad_req, 0);
        check("badreq_ready2", ready, 1);

        // Lock drops for 5 cycles in RUN.
        pll_lock = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_lock_lost", lock_lost, 1);
        check("drop_vrst", video_rst_n, 0);
        check("drop_ready", ready, 0);
        @(negedge clk);
        pll_lock = 1'b1;
        wait_ready("relock", 7000, cyc);
        check("relock_sticky", lock_lost, 1);
        check("relock_meas", (meas_count >= 113 && meas_count <= 119), 1);

        // Valid request to 480p lands in the same cycle the synchronised lock drop is seen.
        pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mode_sel = 2'd0; mode_req = 1'b1;
        @(negedge clk);
        mode_req = 1'b0;
        check("race_mode", pll_mode, 0);
        check("race_lock_lost", lock_lost, 0);
        check("race_pll_reset", pll_reset, 1);
        check("race_ready", ready, 0);
        repeat (15) @(negedge clk);
        check("race_rst_hold", pll_reset, 1);
        @(negedge clk);
        check("race_rst_done", pll_reset, 0);
        tog_half = 2370.370;   // 64 pixel clocks at 27 MHz
        pll_lock = 1'b1;
        wait_ready("m480", 7000, cyc);
        check("m480_mode", pll_mode, 0);
        check("m480_meas", (meas_count >= 39 && meas_count <= 45), 1);
        check("m480_lock_lost", lock_lost, 0);

        // 1080p pixel rate while 720p is selected: every window fails.
        tog_half = 430.976;    // 64 pixel clocks at 148.5 MHz
        prev_meas = meas_count;
        mode_sel = 2'd1; mode_req = 1'b1;
        @(negedge clk);
        mode_req = 1'b0;
        cyc = 0;
        ready_seen = 0;
        while (meas_count == prev_meas && cyc < 7000) begin
            @(negedge clk);
            cyc++;
        end
        check("wrong_meas", (meas_count >= 229 && meas_count <= 235), 1);
        check("wrong_not_ready", ready, 0);
        cyc = 0;
        while (error !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            if (ready) ready_seen = 1;
            cyc++;
        end
        check("wrong_error", error, 1);
        check("wrong_never_ready", ready_seen, 0);
        check("wrong_pll_reset", pll_reset, 1);
        repeat (50) @(negedge clk);
        check("fail_hold_error", error, 1);
        check("fail_hold_vrst", video_rst_n, 0);
        mode_sel = 2'd2; mode_req = 1'b1;
        @(negedge clk);
        mode_req = 1'b0;
        check("m1080_error_clr", error, 0);
        wait_ready("m1080", 7000, cyc);
        check("m1080_mode", pll_mode, 2);
        check("m1080_meas", (meas_count >= 229 && meas_count <= 235), 1);

        // Async reset mid-RUN, then lock never comes back.
        #5;
        rst_n = 1'b0;
        pll_lock = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4060) @(negedge clk);
        check("timeout_early_error", error, 0);
        repeat (10) @(negedge clk);
        check("timeout_error", error, 1);
        check("timeout_pll_reset", pll_reset, 1);
        check("timeout_ready", ready, 0);
        repeat (100) @(negedge clk);
        check("timeout_hold_error", error, 1);
        check("timeout_hold_pll_reset", pll_reset, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
